// File: rtl/aud_time_counter.sv
// Elapsed-time tracker for the audio recorder: record length and play position
// in whole seconds of audio content, with play advancing at content rate.
module aud_time_counter #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int MAX_SEC = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rec,
    input  logic       i_play,
    input  logic       i_stop,
    input  logic [2:0] i_speed,
    input  logic       i_fast,
    input  logic       i_slow,
    output logic [5:0] o_record_time,
    output logic [5:0] o_play_time,
    output logic       o_rec_full,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [5:0]  MAX_T = 6'(MAX_SEC);
    localparam logic [27:0] HZ    = 28'(CLK_HZ);

    state_t      state, state_next;
    logic [26:0] acc, acc_next;
    logic [5:0]  rec_time, rec_next;
    logic [5:0]  play_time, play_next;
    logic [4:0]  cfg_q, cfg_now;
    logic        cfg_changed;
    logic [3:0]  step_n, step_d;
    logic [27:0] thr, sum;
    logic        sec_done;
    logic        count_rec, count_play;

    // Step pair (N, D): content advances N/D seconds per CLK_HZ wall cycles.
    always_comb begin
        cfg_now     = {i_fast, i_slow, i_speed};
        cfg_changed = (cfg_now != cfg_q);
        step_n      = 4'd1;
        step_d      = 4'd1;
        if (state == PLAY) begin
            if (i_fast)
                step_n = {1'b0, i_speed} + 4'd1;
            else if (i_slow)
                step_d = {1'b0, i_speed} + 4'd1;
        end
        thr      = HZ * 28'(step_d);
        sum      = {1'b0, acc} + 28'(step_n);
        sec_done = (sum >= thr);
    end

    always_comb begin
        state_next = state;
        rec_next   = rec_time;
        play_next  = play_time;
        acc_next   = acc;
        count_rec  = 1'b0;
        count_play = 1'b0;

        if (i_stop) begin
            state_next = IDLE;
            play_next  = '0;
            acc_next   = '0;
        end else if (i_rec) begin
            if (state != REC) begin
                state_next = REC;
                rec_next   = '0;
                play_next  = '0;
                acc_next   = '0;
            end else if (rec_time == MAX_T) begin
                acc_next = '0;
            end else begin
                count_rec = 1'b1;
            end
        end else if (state == REC) begin
            state_next = IDLE;
            acc_next   = '0;
        end else if (i_play) begin
            if (state == IDLE) begin
                state_next = PLAY;
                play_next  = '0;
                acc_next   = '0;
            end else if (state == PAUSE) begin
                state_next = PLAY;
            end else if (play_time != rec_time) begin
                count_play = 1'b1;
            end
        end else if (state == PLAY) begin
            state_next = PAUSE;
        end

        // A speed-setting change restarts the fractional second from zero.
        if (cfg_changed) begin
            acc_next = '0;
        end else if (count_rec || count_play) begin
            if (sec_done) begin
                acc_next = 27'(sum - thr);
                if (count_rec)
                    rec_next = rec_time + 6'd1;
                else
                    play_next = play_time + 6'd1;
            end else begin
                acc_next = sum[26:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            acc        <= '0;
            rec_time   <= '0;
            play_time  <= '0;
            cfg_q      <= '0;
            o_rec_full <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            rec_time   <= rec_next;
            play_time  <= play_next;
            cfg_q      <= cfg_now;
            o_rec_full <= (rec_next == MAX_T);
        end
    end

    assign o_record_time = rec_time;
    assign o_play_time   = play_time;
    assign o_state       = state;

endmodule

// File: tb/tb_aud_time_counter.sv
// Bench for aud_time_counter: directed scenarios plus random traffic, every
// cycle compared against a second-counting reference model.
module tb_aud_time_counter;

    localparam int CLK_HZ  = 100;
    localparam int MAX_SEC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rec, play, stop, fast, slow;
    logic [2:0] speed;
    logic [5:0] record_time, play_time;
    logic       rec_full;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    int         m_state, m_rt, m_pt, m_acc;
    logic [4:0] m_cfg;

    aud_time_counter #(.CLK_HZ(CLK_HZ), .MAX_SEC(MAX_SEC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rec        (rec),
        .i_play       (play),
        .i_stop       (stop),
        .i_speed      (speed),
        .i_fast       (fast),
        .i_slow       (slow),
        .o_record_time(record_time),
        .o_play_time  (play_time),
        .o_rec_full   (rec_full),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic s,
                                 input logic f, input logic sl, input logic [2:0] sp);
        rec   = r;
        play  = p;
        stop  = s;
        fast  = f;
        slow  = sl;
        speed = sp;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rt    = 0;
        m_pt    = 0;
        m_acc   = 0;
        m_cfg   = '0;
    endtask

    // Content time accrues as rate/CLK_HZ seconds per cycle, kept as an integer
    // numerator over CLK_HZ*D so fractional seconds carry over exactly.
    task automatic model_step();
        logic [4:0] cfg_now;
        bit changed, grow_rec, grow_play;
        int rate_num, rate_den, one_sec;
        cfg_now   = {fast, slow, speed};
        changed   = (cfg_now != m_cfg);
        m_cfg     = cfg_now;
        grow_rec  = 0;
        grow_play = 0;

        if (stop) begin
            m_state = 0; m_pt = 0; m_acc = 0;
        end else if (rec) begin
            if (m_state != 1) begin
                m_state = 1; m_rt = 0; m_pt = 0; m_acc = 0;
            end else if (m_rt == MAX_SEC) m_acc = 0;
            else grow_rec = 1;
        end else if (m_state == 1) begin
            m_state = 0; m_acc = 0;
        end else if (play) begin
            if (m_state == 0) begin
                m_state = 2; m_pt = 0; m_acc = 0;
            end else if (m_state == 3) m_state = 2;
            else if (m_pt < m_rt) grow_play = 1;
        end else if (m_state == 2) begin
            m_state = 3;
        end

        if (changed) begin
            m_acc = 0;
        end else if (grow_rec || grow_play) begin
            rate_num = (grow_play && fast) ? int'(speed) + 1 : 1;
            rate_den = (grow_play && !fast && slow) ? int'(speed) + 1 : 1;
            one_sec  = CLK_HZ * rate_den;
            m_acc    = m_acc + rate_num;
            if (m_acc >= one_sec) begin
                m_acc = m_acc - one_sec;
                if (grow_rec) m_rt++;
                else m_pt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checkOutput("state", int'(state), m_state);
        checkOutput("record_time", int'(record_time), m_rt);
        checkOutput("play_time", int'(play_time), m_pt);
        checkOutput("rec_full", int'(rec_full), int'(m_rt == MAX_SEC));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_record", int'(record_time), 0);
        checkOutput("reset_play", int'(play_time), 0);
        checkOutput("reset_full", int'(rec_full), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] scenario: 1x record");
        applyStimulus(1, 0, 0, 0, 0, 3'd0);
        ticks(100);
        checkOutput("rec_before_1s", int'(record_time), 0);
        tick();
        checkOutput("rec_at_1s", int'(record_time), 1);
        ticks(149);
        applyStimulus(0, 0, 0, 0, 0, 3'd0);
        tick();
        checkOutput("rec_len_2", int'(record_time), 2);
        checkOutput("rec_drop_idle", int'(state), 0);

        $display("[TB] scenario: record saturation");
        applyStimulus(1, 0, 0, 0, 0, 3'd0);
        ticks(400);
        checkOutput("sat_before", int'(record_time), 3);
        checkOutput("sat_full_before", int'(rec_full), 0);
        tick();
        checkOutput("sat_reach", int'(record_time), 4);
        checkOutput("sat_full", int'(rec_full), 1);
        ticks(199);
        checkOutput("sat_hold", int'(record_time), 4);
        checkOutput("sat_state", int'(state), 1);
        applyStimulus(0, 0, 0, 0, 0, 3'd0);
        tick();

        $display("[TB] scenario: fast 4x play");
        applyStimulus(0, 1, 0, 1, 0, 3'd3);
        ticks(25);
        checkOutput("fast_before", int'(play_time), 0);
        tick();
        checkOutput("fast_1s", int'(play_time), 1);
        ticks(75);
        checkOutput("fast_clamp", int'(play_time), 4);
        ticks(49);
        checkOutput("fast_clamp_hold", int'(play_time), 4);
        checkOutput("fast_clamp_state", int'(state), 2);

        $display("[TB] scenario: stop priority");
        applyStimulus(0, 1, 1, 1, 0, 3'd3);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 3'd3);
        ticks(80);
        checkOutput("stop_pre_play", int'(play_time), 3);
        applyStimulus(0, 1, 1, 1, 0, 3'd3);
        tick();
        checkOutput("stop_state", int'(state), 0);
        checkOutput("stop_play", int'(play_time), 0);
        checkOutput("stop_record", int'(record_time), 4);
        applyStimulus(0, 1, 0, 1, 0, 3'd3);
        tick();
        checkOutput("stop_replay_state", int'(state), 2);
        checkOutput("stop_replay_time", int'(play_time), 0);

        $display("[TB] scenario: slow 2x with pause");
        applyStimulus(0, 0, 1, 1, 0, 3'd3);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 3'd1);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 3'd1);
        ticks(200);
        checkOutput("slow_before", int'(play_time), 0);
        tick();
        checkOutput("slow_1s", int'(play_time), 1);
        ticks(50);
        applyStimulus(0, 0, 0, 0, 1, 3'd1);
        tick();
        checkOutput("pause_state", int'(state), 3);
        checkOutput("pause_time", int'(play_time), 1);
        applyStimulus(0, 1, 0, 0, 1, 3'd1);
        ticks(150);
        checkOutput("resume_before", int'(play_time), 1);
        tick();
        checkOutput("resume_2s", int'(play_time), 2);

        $display("[TB] scenario: reset mid-record");
        applyStimulus(1, 0, 0, 0, 0, 3'd0);
        ticks(150);
        checkOutput("prereset_rec", int'(record_time), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("async_state", int'(state), 0);
        checkOutput("async_record", int'(record_time), 0);
        checkOutput("async_play", int'(play_time), 0);
        checkOutput("async_full", int'(rec_full), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("rerec_state", int'(state), 1);
        ticks(99);
        checkOutput("rerec_before", int'(record_time), 0);
        tick();
        checkOutput("rerec_1s", int'(record_time), 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(999) < 5) rec = ~rec;
            if ($urandom_range(999) < 10) play = ~play;
            stop = ($urandom_range(999) < 3);
            if ($urandom_range(999) < 5) begin
                fast  = 1'($urandom_range(1));
                slow  = 1'($urandom_range(1));
                speed = 3'($urandom_range(7));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
